// File: rtl/pc_gen.sv
// pc_gen: program-counter generator.
// Offers a PC to fetch with a valid/ready handshake, waits for the
// instruction to retire, then computes the next PC from trap, jump or
// sequential flow and counts the retired instructions.
module pc_gen #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h2000_0000),
   parameter int unsigned     C_EXT     = 0
) (
   input  logic            i_clock,
   input  logic            reset,
   input  logic            i_done,
   input  logic            i_jump,
   input  logic [XLEN-1:0] i_target,
   input  logic            i_trap,
   input  logic [XLEN-1:0] i_tvec,
   input  logic            i_is_c,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_pc,
   output logic            o_valid,
   output logic            o_misalign,
   output logic [31:0]     o_retired
);

   localparam int unsigned     RET_W    = 32;
   localparam logic [XLEN-1:0] STEP_W   = XLEN'(4);
   localparam logic [XLEN-1:0] STEP_C   = XLEN'(2);
   // Clears the two mode bits of the trap vector.
   localparam logic [XLEN-1:0] TVEC_MSK = ~XLEN'(3);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_nxt;
   logic [XLEN-1:0]    pc_nxt;
   logic [XLEN-1:0]    seq_pc;
   logic [RET_W-1:0]   retired_nxt;
   logic               valid_nxt;
   logic               misalign_nxt;
   logic               use_c;

   // Alignment rule: 4-byte without C, 2-byte with C.
   function automatic logic misaligned(input logic [XLEN-1:0] pc);
      if (C_EXT != 0) begin
         return pc[0];
      end
      return |pc[1:0];
   endfunction

   // Sequential step size depends on the retired instruction length.
   always_comb begin
      use_c  = 1'b0;
      use_c  = (C_EXT != 0) && i_is_c;
      seq_pc = o_pc + (use_c ? STEP_C : STEP_W);
   end

   // Next-state, next-PC and retire-count logic.
   always_comb begin
      state_nxt   = state_q;
      pc_nxt      = o_pc;
      retired_nxt = o_retired;
      case (state_q)
         ST_BOOT: begin
            state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (i_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_done) begin
               state_nxt   = ST_ISSUE;
               retired_nxt = o_retired + RET_W'(1);
               if (i_trap) begin
                  pc_nxt = i_tvec & TVEC_MSK;
               end else if (i_jump) begin
                  pc_nxt = i_target;
               end else begin
                  pc_nxt = seq_pc;
               end
            end
         end
         default: begin
            state_nxt = ST_BOOT;
         end
      endcase
      valid_nxt    = (state_nxt == ST_ISSUE);
      misalign_nxt = misaligned(pc_nxt);
   end

   // State and output registers; synchronous reset wins over everything.
   always_ff @(posedge i_clock) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         o_pc       <= RESET_VEC;
         o_valid    <= 1'b0;
         o_misalign <= misaligned(RESET_VEC);
         o_retired  <= '0;
      end else begin
         state_q    <= state_nxt;
         o_pc       <= pc_nxt;
         o_valid    <= valid_nxt;
         o_misalign <= misalign_nxt;
         o_retired  <= retired_nxt;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen.
// Two instances share stimulus: dut_a without compressed support,
// dut_b with it.
module tb_pc_gen;

   logic        i_clock;
   logic        reset;
   logic        i_done;
   logic        i_jump;
   logic [31:0] i_target;
   logic        i_trap;
   logic [31:0] i_tvec;
   logic        i_is_c;
   logic        i_ready;

   logic [31:0] a_pc, b_pc;
   logic        a_valid, b_valid;
   logic        a_mis, b_mis;
   logic [31:0] a_ret, b_ret;

   int checks;
   int failures;

   pc_gen #(.XLEN(32), .RESET_VEC(32'h2000_0000), .C_EXT(0)) dut_a (
      .i_clock(i_clock), .reset(reset), .i_done(i_done), .i_jump(i_jump),
      .i_target(i_target), .i_trap(i_trap), .i_tvec(i_tvec), .i_is_c(i_is_c),
      .i_ready(i_ready), .o_pc(a_pc), .o_valid(a_valid),
      .o_misalign(a_mis), .o_retired(a_ret)
   );

   pc_gen #(.XLEN(32), .RESET_VEC(32'h2000_0000), .C_EXT(1)) dut_b (
      .i_clock(i_clock), .reset(reset), .i_done(i_done), .i_jump(i_jump),
      .i_target(i_target), .i_trap(i_trap), .i_tvec(i_tvec), .i_is_c(i_is_c),
      .i_ready(i_ready), .o_pc(b_pc), .o_valid(b_valid),
      .o_misalign(b_mis), .o_retired(b_ret)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   // Advance one edge; sampling and driving happen 1ns after it.
   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   // ISSUE -> WAIT with i_ready high.
   task automatic accept();
      i_ready = 1'b1;
      tick();
   endtask

   // One retire pulse in WAIT with the given side-band values.
   task automatic retire(input logic jump, input logic trap, input logic [31:0] target,
                         input logic [31:0] tvec, input logic is_c);
      i_done = 1'b1; i_jump = jump; i_trap = trap;
      i_target = target; i_tvec = tvec; i_is_c = is_c;
      tick();
      i_done = 1'b0; i_jump = 1'b0; i_trap = 1'b0;
      i_target = 32'hDEAD_BEEF; i_tvec = 32'hFFFF_FFFF; i_is_c = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; i_ready = 1'b1; i_done = 1'b1;
      tick(); tick(); tick();
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", a_valid); end
      checks++; if (a_pc !== 32'h2000_0000) begin failures++; $display("FAIL rst_pc got=%h exp=20000000", a_pc); end
      checks++; if (a_mis !== 1'b0) begin failures++; $display("FAIL rst_mis got=%0b exp=0", a_mis); end
      checks++; if (a_ret !== 32'd0) begin failures++; $display("FAIL rst_ret got=%0d exp=0", a_ret); end
      checks++; if (b_pc !== 32'h2000_0000) begin failures++; $display("FAIL rst_pc_b got=%h exp=20000000", b_pc); end
      // Release; i_done held high during BOOT must be ignored.
      reset = 1'b0;
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%0b exp=0", a_valid); end
      tick();
      i_done = 1'b0;
      checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL boot_issue_valid got=%0b exp=1", a_valid); end
      checks++; if (a_pc !== 32'h2000_0000) begin failures++; $display("FAIL boot_pc got=%h exp=20000000", a_pc); end
      checks++; if (a_mis !== 1'b0) begin failures++; $display("FAIL boot_mis got=%0b exp=0", a_mis); end
      checks++; if (a_ret !== 32'd0) begin failures++; $display("FAIL boot_ret got=%0d exp=0", a_ret); end
   endtask

   task automatic test_sequential();
      accept();
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL wait_valid got=%0b exp=0", a_valid); end
      retire(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL seq_valid got=%0b exp=1", a_valid); end
      checks++; if (a_pc !== 32'h2000_0004) begin failures++; $display("FAIL seq_pc got=%h exp=20000004", a_pc); end
      checks++; if (a_ret !== 32'd1) begin failures++; $display("FAIL seq_ret got=%0d exp=1", a_ret); end
      checks++; if (b_pc !== 32'h2000_0004) begin failures++; $display("FAIL seq_pc_b got=%h exp=20000004", b_pc); end
   endtask

   task automatic test_compressed();
      accept();
      retire(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      checks++; if (a_pc !== 32'h2000_0008) begin failures++; $display("FAIL c_ignored_pc got=%h exp=20000008", a_pc); end
      checks++; if (b_pc !== 32'h2000_0006) begin failures++; $display("FAIL c_step_pc got=%h exp=20000006", b_pc); end
      checks++; if (b_mis !== 1'b0) begin failures++; $display("FAIL c_step_mis got=%0b exp=0", b_mis); end
      checks++; if (b_ret !== 32'd2) begin failures++; $display("FAIL c_ret got=%0d exp=2", b_ret); end
   endtask

   task automatic test_trap_priority();
      accept();
      retire(1'b1, 1'b1, 32'h0000_0100, 32'h8000_0001, 1'b0);
      checks++; if (a_pc !== 32'h8000_0000) begin failures++; $display("FAIL trap_pc got=%h exp=80000000", a_pc); end
      checks++; if (b_pc !== 32'h8000_0000) begin failures++; $display("FAIL trap_pc_b got=%h exp=80000000", b_pc); end
      checks++; if (a_mis !== 1'b0) begin failures++; $display("FAIL trap_mis got=%0b exp=0", a_mis); end
      checks++; if (a_ret !== 32'd3) begin failures++; $display("FAIL trap_ret got=%0d exp=3", a_ret); end
   endtask

   task automatic test_misalign();
      accept();
      retire(1'b1, 1'b0, 32'h2000_0002, 32'h0, 1'b0);
      checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL mis2_valid got=%0b exp=1", a_valid); end
      checks++; if (a_pc !== 32'h2000_0002) begin failures++; $display("FAIL jump_pc got=%h exp=20000002", a_pc); end
      checks++; if (a_mis !== 1'b1) begin failures++; $display("FAIL mis2_a got=%0b exp=1", a_mis); end
      checks++; if (b_mis !== 1'b0) begin failures++; $display("FAIL mis2_b got=%0b exp=0", b_mis); end
      accept();
      retire(1'b1, 1'b0, 32'h2000_0001, 32'h0, 1'b0);
      checks++; if (a_mis !== 1'b1) begin failures++; $display("FAIL mis1_a got=%0b exp=1", a_mis); end
      checks++; if (b_mis !== 1'b1) begin failures++; $display("FAIL mis1_b got=%0b exp=1", b_mis); end
      checks++; if (a_ret !== 32'd5) begin failures++; $display("FAIL mis_ret got=%0d exp=5", a_ret); end
   endtask

   task automatic test_stall();
      // In ISSUE at 0x2000_0001 with misalign set; fetch stalls.
      i_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         i_done = i[0]; i_jump = 1'b1; i_target = 32'h4000_0000 + 32'(i);
         tick();
         checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%0b exp=1", i, a_valid); end
         checks++; if (a_pc !== 32'h2000_0001) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=20000001", i, a_pc); end
         checks++; if (a_mis !== 1'b1) begin failures++; $display("FAIL stall_mis[%0d] got=%0b exp=1", i, a_mis); end
         checks++; if (a_ret !== 32'd5) begin failures++; $display("FAIL stall_ret[%0d] got=%0d exp=5", i, a_ret); end
      end
      i_done = 1'b0; i_jump = 1'b0;
   endtask

   task automatic test_wrap();
      accept();
      retire(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);
      checks++; if (a_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrapset_pc got=%h exp=fffffffc", a_pc); end
      accept();
      retire(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checks++; if (a_pc !== 32'h0000_0000) begin failures++; $display("FAIL wrap_pc got=%h exp=00000000", a_pc); end
      checks++; if (b_pc !== 32'h0000_0000) begin failures++; $display("FAIL wrap_pc_b got=%h exp=00000000", b_pc); end
      checks++; if (a_mis !== 1'b0) begin failures++; $display("FAIL wrap_mis got=%0b exp=0", a_mis); end
      accept();
      retire(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0);
      accept();
      retire(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      checks++; if (b_pc !== 32'h0000_0000) begin failures++; $display("FAIL cwrap_pc_b got=%h exp=00000000", b_pc); end
      checks++; if (a_pc !== 32'h0000_0002) begin failures++; $display("FAIL cwrap_pc_a got=%h exp=00000002", a_pc); end
      checks++; if (a_mis !== 1'b1) begin failures++; $display("FAIL cwrap_mis_a got=%0b exp=1", a_mis); end
      checks++; if (a_ret !== 32'd9) begin failures++; $display("FAIL wrap_ret got=%0d exp=9", a_ret); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc;
      accept();
      retire(1'b1, 1'b0, 32'h3000_0000, 32'h0, 1'b0);
      exp_pc = 32'h3000_0000;
      for (int i = 0; i < 3; i++) begin
         accept();
         retire(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
         exp_pc = exp_pc + 32'd4;
         checks++; if (a_pc !== exp_pc) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, a_pc, exp_pc); end
         checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", i, a_valid); end
      end
      checks++; if (a_ret !== 32'd13) begin failures++; $display("FAIL b2b_ret got=%0d exp=13", a_ret); end
   endtask

   task automatic test_reset_mid();
      accept();
      reset = 1'b1; i_done = 1'b1; i_jump = 1'b1; i_target = 32'h5555_5554;
      tick();
      checks++; if (a_pc !== 32'h2000_0000) begin failures++; $display("FAIL midrst_pc got=%h exp=20000000", a_pc); end
      checks++; if (a_ret !== 32'd0) begin failures++; $display("FAIL midrst_ret got=%0d exp=0", a_ret); end
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", a_valid); end
      checks++; if (b_ret !== 32'd0) begin failures++; $display("FAIL midrst_ret_b got=%0d exp=0", b_ret); end
      reset = 1'b0; i_done = 1'b0; i_jump = 1'b0;
      tick();
      checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL midrst_reissue got=%0b exp=1", a_valid); end
      checks++; if (a_pc !== 32'h2000_0000) begin failures++; $display("FAIL midrst_reissue_pc got=%h exp=20000000", a_pc); end
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; i_done = 1'b0; i_jump = 1'b0; i_trap = 1'b0;
      i_target = '0; i_tvec = '0; i_is_c = 1'b0; i_ready = 1'b0;
      test_reset();
      test_sequential();
      test_compressed();
      test_trap_priority();
      test_misalign();
      test_stall();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and target width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h2000_0000, PC value loaded by reset.
REQ-003 SHALL have parameter C_EXT, default 0; 1 enables 2-byte sequential steps and 2-byte alignment.
REQ-004 SHALL have port i_clock, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port i_done, input, 1, one-cycle pulse: current instruction retired.
REQ-007 SHALL have port i_jump, input, 1, retired instruction redirects to i_target; sampled with i_done.
REQ-008 SHALL have port i_target, input, XLEN, jump/branch target.
REQ-009 SHALL have port i_trap, input, 1, retired instruction raises a trap; sampled with i_done.
REQ-010 SHALL have port i_tvec, input, XLEN, trap vector base; bits [1:0] are mode bits.
REQ-011 SHALL have port i_is_c, input, 1, retired instruction is 16-bit; ignored when C_EXT=0.
REQ-012 SHALL have port i_ready, input, 1, fetch stage accepts the offered PC.
REQ-013 SHALL have port o_pc, output, XLEN, current PC.
REQ-014 SHALL have port o_valid, output, 1, o_pc offered to fetch.
REQ-015 SHALL have port o_misalign, output, 1, offered PC violates alignment; qualified by o_valid.
REQ-016 SHALL have port o_retired, output, 32, count of accepted i_done pulses.

Function
REQ-017 SHALL implement a three-state FSM: BOOT, ISSUE, WAIT.
REQ-018 BOOT SHALL last exactly one cycle after reset deasserts, then go to ISSUE.
REQ-019 In ISSUE, o_valid SHALL be 1; o_pc and o_misalign SHALL hold stable until i_ready=1.
REQ-020 ISSUE with i_ready=1 SHALL move to WAIT on the next edge; o_valid SHALL be 0 in BOOT and WAIT.
REQ-021 In WAIT, an i_done pulse SHALL update the PC and move to ISSUE on the same edge, so o_valid rises one cycle after i_done.
REQ-022 i_done in BOOT or ISSUE SHALL be ignored: no PC change, no count change.
REQ-023 Next-PC priority on an accepted i_done: i_trap, then i_jump, then sequential.
REQ-024 Trap next-PC SHALL be {i_tvec[XLEN-1:2], 2'b00}, which is always aligned.
REQ-025 Jump next-PC SHALL be i_target unmodified.
REQ-026 Sequential next-PC SHALL be o_pc+2 when C_EXT=1 and i_is_c=1; otherwise o_pc+4.
REQ-027 Sequential arithmetic SHALL be modulo 2^XLEN, wrapping without a flag.
REQ-028 o_misalign SHALL be registered with the PC: 1 when C_EXT=0 and pc[1:0]!=0, or when C_EXT=1 and pc[0]=1.
REQ-029 o_retired SHALL increment by 1 per accepted i_done and wrap from 32'hFFFF_FFFF to 0.
REQ-030 i_jump, i_trap, i_target, i_tvec and i_is_c SHALL be don't-care when no i_done is accepted.

Reset
REQ-031 reset SHALL take priority over all other inputs, including mid-handshake and simultaneous i_done.
REQ-032 While reset=1, the block SHALL hold: state BOOT, o_pc=RESET_VEC, o_valid=0, o_misalign=RESET_VEC misalignment per REQ-028, o_retired=0.
REQ-033 After reset deasserts at edge N, o_valid SHALL first be 1 in the cycle after edge N+1.

Verification
REQ-034 Reset then release, i_ready=1 -> o_valid=0 for one cycle, then o_valid=1, o_pc=32'h2000_0000, o_misalign=0.
REQ-035 Issue accepted; i_done with no jump or trap, C_EXT=0 -> next issue o_pc=32'h2000_0004, o_retired=1.
REQ-036 i_done with i_jump=1, i_trap=1, i_target=32'h100, i_tvec=32'h8000_0001 -> o_pc=32'h8000_0000.
REQ-037 i_jump=1, i_target=32'h2000_0002, C_EXT=0 -> o_valid=1, o_misalign=1; with C_EXT=1 -> o_misalign=0.
REQ-038 Two further cases: pc=32'hFFFF_FFFC with a sequential i_done -> o_pc=0; reset asserted in WAIT with a simultaneous i_done -> o_pc=RESET_VEC and o_retired=0.
REQ-039 i_ready held 0 for 5 cycles in ISSUE -> o_valid and o_pc stable; i_done pulses in that window are ignored.
